// File: rtl/module_bcd_to_bin.sv
// Sequential packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Ports:
//   i_clk    - clock, rising edge
//   i_rst_n  - synchronous active-low reset
//   i_start  - conversion request, honoured only when not busy
//   i_bcd    - packed BCD operand, digit 0 in [3:0], captured on the accepting edge
//   o_bin    - binary result, held between o_done pulses
//   o_busy   - conversion in progress
//   o_done   - one-cycle pulse when o_bin/o_error are valid
//   o_error  - last accepted operand contained a digit > 9
module module_bcd_to_bin #(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned BIN_W    = 14
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [4*N_DIGITS-1:0]   i_bcd,
  output logic [BIN_W-1:0]        o_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int unsigned DW = 4 * N_DIGITS;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dig_q, dig_d;
  logic [DW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BIN_W-1:0] bin_d;
  logic             busy_d, done_d, error_d;

  logic             bad_c;
  logic [DW-1:0]    dig_sh_c;
  logic [DW-1:0]    acc_sh_c;

  // Flag any non-decimal digit in the incoming operand.
  always_comb begin
    bad_c = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (i_bcd[4*i +: 4] > 4'd9) bad_c = 1'b1;
    end
  end

  // One reverse double-dabble step: shift right, then correct digits that
  // picked up a half-ten (worth 8 after the shift, should be 5).
  always_comb begin
    {dig_sh_c, acc_sh_c} = {dig_q, acc_q} >> 1;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (dig_sh_c[4*i +: 4] >= 4'd8) dig_sh_c[4*i +: 4] = dig_sh_c[4*i +: 4] - 4'd3;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bin_d   = o_bin;
    busy_d  = o_busy;
    done_d  = 1'b0;
    error_d = o_error;

    case (state_q)
      IDLE, DONE: begin
        busy_d = 1'b0;
        if (state_q == DONE) state_d = IDLE;
        if (i_start) begin
          error_d = 1'b0;
          dig_d   = i_bcd;
          acc_d   = '0;
          cnt_d   = '0;
          if (bad_c) begin
            // Invalid operand short-circuits straight to a flagged result.
            state_d = DONE;
            bin_d   = '0;
            error_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end

      SHIFT: begin
        dig_d = dig_sh_c;
        acc_d = acc_sh_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bin_d   = BIN_W'(acc_sh_c);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      dig_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      o_bin   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_error <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      o_bin   <= bin_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
      o_error <= error_d;
    end
  end

endmodule

// File: tb/tb_module_bcd_to_bin.sv
// Self-checking bench for module_bcd_to_bin: directed vectors plus a
// decimal round trip over 0..4095.
module tb_module_bcd_to_bin;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bcd;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic        error;

  int n_tests = 0;
  int n_fail  = 0;

  module_bcd_to_bin #(.N_DIGITS(4), .BIN_W(14)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_bcd   (bcd),
    .o_bin   (bin),
    .o_busy  (busy),
    .o_done  (done),
    .o_error (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // Start one conversion and wait (bounded) for o_done; n counts edges after acceptance.
  task automatic conv(input string tag, input logic [15:0] op, input int exp_bin,
                      input logic exp_err, input int exp_n, input bit full);
    int n;
    int nbusy;
    bcd   = op;
    start = 1'b1;
    tick();
    start = 1'b0;
    bcd   = 16'($urandom);
    if (full) check({tag, "_err_at_accept"}, 32'(error), 32'(exp_err));
    n     = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    check({tag, "_bin"}, 32'(bin), 32'(exp_bin));
    check({tag, "_err"}, 32'(error), 32'(exp_err));
    if (full) begin
      check({tag, "_latency"}, 32'(n), 32'(exp_n));
      check({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_n));
      check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    end
    tick();
    if (full) begin
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_bin_hold"}, 32'(bin), 32'(exp_bin));
      check({tag, "_err_hold"}, 32'(error), 32'(exp_err));
    end
  endtask

  initial begin
    int n;
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    bcd   = 16'h0000;
    tick();
    tick();
    check("rst_bin",   32'(bin),   32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_error", 32'(error), 32'd0);
    rst_n = 1'b1;
    tick();

    conv("zero",   16'h0000, 0,    1'b0, 16, 1'b1);
    conv("max",    16'h9999, 9999, 1'b0, 16, 1'b1);
    conv("v1234",  16'h1234, 1234, 1'b0, 16, 1'b1);
    conv("v0009",  16'h0009, 9,    1'b0, 16, 1'b1);
    conv("bad12A4",16'h12A4, 0,    1'b1, 0,  1'b1);
    conv("v0042",  16'h0042, 42,   1'b0, 16, 1'b1);
    conv("bad000A",16'h000A, 0,    1'b1, 0,  1'b1);
    conv("badF000",16'hF000, 0,    1'b1, 0,  1'b1);
    conv("v8080",  16'h8080, 8080, 1'b0, 16, 1'b1);

    // Starts during SHIFT are ignored; a start in DONE is taken back-to-back.
    bcd   = 16'h0500;
    start = 1'b1;
    tick();
    start = 1'b0;
    n     = 0;
    while (!done && n < 40) begin
      start = (n == 3 || n == 10);
      bcd   = 16'h0777;
      tick();
      n++;
    end
    start = 1'b0;
    check("ign_latency", 32'(n), 32'd16);
    check("ign_bin", 32'(bin), 32'd500);
    bcd   = 16'h0007;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_done_drop", 32'(done), 32'd0);
    check("b2b_busy_rise", 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    check("b2b_latency", 32'(n), 32'd16);
    check("b2b_bin", 32'(bin), 32'd7);
    tick();

    // Reset mid-conversion aborts without a done pulse.
    bcd   = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_bin",   32'(bin),   32'd0);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_error", 32'(error), 32'd0);
    ndone = 0;
    repeat (20) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    conv("after_abort", 16'h0321, 321, 1'b0, 16, 1'b1);

    // Decimal round trip.
    for (int v = 0; v < 4096; v++) begin
      conv("rt", to_bcd(v), v, 1'b0, 16, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
